// File: rtl/pacman_move_ctrl_pkg.sv
// Shared types and constants for Pac-Man movement: headings, keycodes,
// grid bounds and the movement FSM states.
package pac_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  // Highest legal tile index on either axis.
  localparam logic [4:0] GRID_MAX = 5'd13;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_CENTER = 2'd1,
    ST_MOVE   = 2'd2
  } state_t;

endpackage

// File: rtl/pacman_move_ctrl_if.sv
// Bundle between the movement controller and its surroundings: frame strobe,
// start screen, keyboard, wall-check flags in; position/heading out.
interface pacman_move_ctrl_if;
  import pac_pkg::*;

  logic       frame_clk;
  logic       Starting_screen;
  logic [7:0] keycode;
  logic       final_check_left;
  logic       final_check_right;
  logic       final_check_up;
  logic       final_check_down;
  logic [4:0] curr_X;
  logic [4:0] curr_Y;
  logic [3:0] offset;
  dir_t       dir;
  logic       moving;
  logic       tile_tick;

  // Controller side.
  modport master (
    input  frame_clk, Starting_screen, keycode,
    input  final_check_left, final_check_right, final_check_up, final_check_down,
    output curr_X, curr_Y, offset, dir, moving, tile_tick
  );

  // Environment side (wall checker, keyboard, renderer).
  modport slave (
    output frame_clk, Starting_screen, keycode,
    output final_check_left, final_check_right, final_check_up, final_check_down,
    input  curr_X, curr_Y, offset, dir, moving, tile_tick
  );

endinterface

// File: rtl/pacman_move_ctrl_key_decode.sv
// Keycode to heading decoder; WASD map to directions, anything else is ignored.
module key_decode
  import pac_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       valid,
  output dir_t       dir
);

  // Pure lookup; valid drops for unmapped keys.
  always_comb begin
    valid = 1'b1;
    dir   = LEFT;
    case (keycode)
      KEY_W:   dir = UP;
      KEY_S:   dir = DOWN;
      KEY_A:   dir = LEFT;
      KEY_D:   dir = RIGHT;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/pacman_move_ctrl.sv
// Tile-grid movement controller: queues a turn request, walks a sub-tile
// offset on each frame tick and commits tile steps at the end of each tile.
module pacman_move_ctrl
  import pac_pkg::*;
#(
  parameter int         TILE_PX = 16,
  parameter logic [4:0] SPAWN_X = 5'd6,
  parameter logic [4:0] SPAWN_Y = 5'd9
) (
  input  logic               Clk,
  input  logic               Reset_n,
  pacman_move_ctrl_if.master bus
);

  localparam logic [3:0] OFF_LAST = 4'(TILE_PX - 1);

  state_t     state, nxt_state;
  logic [4:0] cx, cy, nxt_cx, nxt_cy;
  logic [3:0] off, nxt_off;
  dir_t       dir_q, nxt_dir;
  dir_t       pend, nxt_pend;
  logic       pend_vld, nxt_pend_vld;
  logic       moving_q, nxt_moving;
  logic       tick_q, nxt_tick;
  logic       key_vld;
  dir_t       key_dir;
  logic [3:0] chk;

  key_decode u_key_decode (
    .keycode (bus.keycode),
    .valid   (key_vld),
    .dir     (key_dir)
  );

  // Flags indexed by the direction encoding.
  assign chk = {bus.final_check_right, bus.final_check_left,
                bus.final_check_down, bus.final_check_up};

  function automatic logic dir_ok(input dir_t d, input logic [3:0] flags);
    return flags[d];
  endfunction

  // Coordinate steps hold at the grid edges instead of wrapping.
  function automatic logic [4:0] step_dec(input logic [4:0] c);
    return (c == 5'd0) ? c : c - 5'd1;
  endfunction

  function automatic logic [4:0] step_inc(input logic [4:0] c);
    return (c >= GRID_MAX) ? c : c + 5'd1;
  endfunction

  // Next-state logic; a key load and a CENTER decision in the same cycle
  // decide on the old pending value and keep the new key queued.
  always_comb begin
    nxt_state    = state;
    nxt_cx       = cx;
    nxt_cy       = cy;
    nxt_off      = off;
    nxt_dir      = dir_q;
    nxt_pend     = pend;
    nxt_pend_vld = pend_vld;
    nxt_moving   = moving_q;
    nxt_tick     = 1'b0;

    if (key_vld) begin
      nxt_pend     = key_dir;
      nxt_pend_vld = 1'b1;
    end

    case (state)
      ST_START: begin
        nxt_cx       = SPAWN_X;
        nxt_cy       = SPAWN_Y;
        nxt_off      = 4'd0;
        nxt_dir      = LEFT;
        nxt_moving   = 1'b0;
        nxt_pend_vld = 1'b0;
        if (bus.frame_clk && !bus.Starting_screen) nxt_state = ST_CENTER;
      end
      ST_CENTER: begin
        nxt_off = 4'd0;
        if (bus.frame_clk) begin
          if (pend_vld && dir_ok(pend, chk)) begin
            nxt_dir      = pend;
            nxt_pend_vld = key_vld;
            nxt_off      = 4'd1;
            nxt_moving   = 1'b1;
            nxt_state    = ST_MOVE;
          end else if (moving_q && dir_ok(dir_q, chk)) begin
            nxt_off   = 4'd1;
            nxt_state = ST_MOVE;
          end else begin
            nxt_moving = 1'b0;
          end
        end
      end
      ST_MOVE: begin
        if (bus.frame_clk) begin
          if (off < OFF_LAST) begin
            nxt_off = off + 4'd1;
          end else begin
            case (dir_q)
              UP:    nxt_cy = step_dec(cy);
              DOWN:  nxt_cy = step_inc(cy);
              LEFT:  nxt_cx = step_dec(cx);
              RIGHT: nxt_cx = step_inc(cx);
              default: ;
            endcase
            nxt_off   = 4'd0;
            nxt_tick  = 1'b1;
            nxt_state = ST_CENTER;
          end
        end
      end
      default: nxt_state = ST_START;
    endcase

    if (bus.Starting_screen) begin
      nxt_state    = ST_START;
      nxt_cx       = SPAWN_X;
      nxt_cy       = SPAWN_Y;
      nxt_off      = 4'd0;
      nxt_dir      = LEFT;
      nxt_pend     = LEFT;
      nxt_pend_vld = 1'b0;
      nxt_moving   = 1'b0;
      nxt_tick     = 1'b0;
    end
  end

  // State and output registers with asynchronous return to spawn.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_START;
      cx       <= SPAWN_X;
      cy       <= SPAWN_Y;
      off      <= 4'd0;
      dir_q    <= LEFT;
      pend     <= LEFT;
      pend_vld <= 1'b0;
      moving_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= nxt_state;
      cx       <= nxt_cx;
      cy       <= nxt_cy;
      off      <= nxt_off;
      dir_q    <= nxt_dir;
      pend     <= nxt_pend;
      pend_vld <= nxt_pend_vld;
      moving_q <= nxt_moving;
      tick_q   <= nxt_tick;
    end
  end

  assign bus.curr_X    = cx;
  assign bus.curr_Y    = cy;
  assign bus.offset    = off;
  assign bus.dir       = dir_q;
  assign bus.moving    = moving_q;
  assign bus.tile_tick = tick_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Directed bench for pacman_move_ctrl: a vector table of key/flag/tick steps
// with hand-computed positions, plus hand-written multi-cycle corner cases.
module tb_pacman_move_ctrl;
  import pac_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pacman_move_ctrl_if bus ();

  pacman_move_ctrl #(
    .TILE_PX (16),
    .SPAWN_X (5'd6),
    .SPAWN_Y (5'd9)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;    // 0 = no key press before the ticks
    logic [3:0] flags;  // {right, left, down, up}
    int         ticks;
    logic [4:0] x;
    logic [4:0] y;
    logic [3:0] off;
    logic [1:0] dir;
    logic       mv;
    int         tt;     // tile_tick pulses expected during the ticks
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [4:0] x, input logic [4:0] y,
                         input logic [3:0] off, input logic [1:0] dir, input logic mv,
                         input int tt_exp, input int tt_act);
    chk({nm, ".curr_X"}, 32'(bus.curr_X), 32'(x));
    chk({nm, ".curr_Y"}, 32'(bus.curr_Y), 32'(y));
    chk({nm, ".offset"}, 32'(bus.offset), 32'(off));
    chk({nm, ".dir"}, 32'(bus.dir), 32'(dir));
    chk({nm, ".moving"}, 32'(bus.moving), 32'(mv));
    chk({nm, ".tile_ticks"}, 32'(tt_act), 32'(tt_exp));
  endtask

  task automatic set_flags(input logic [3:0] f);
    bus.final_check_up    = f[0];
    bus.final_check_down  = f[1];
    bus.final_check_left  = f[2];
    bus.final_check_right = f[3];
  endtask

  task automatic press(input logic [7:0] k);
    bus.keycode = k;
    @(posedge clk); #1;
    bus.keycode = 8'h00;
  endtask

  // Each tick is a one-cycle frame_clk pulse followed by an idle cycle.
  task automatic frame_ticks(input int n, output int tt);
    tt = 0;
    for (int i = 0; i < n; i++) begin
      bus.frame_clk = 1'b1;
      @(posedge clk); #1;
      tt += int'(bus.tile_tick);
      bus.frame_clk = 1'b0;
      @(posedge clk); #1;
      tt += int'(bus.tile_tick);
    end
  endtask

  initial begin
    int tt;
    n_checks = 0;
    n_fail   = 0;

    //            key    flags    ticks  x      y      off    dir mv  tt
    vecs[0]  = '{8'h00, 4'b0000, 3,   5'd6, 5'd9, 4'd0,  2'd2, 1'b0, 0};
    vecs[1]  = '{8'h04, 4'b0100, 1,   5'd6, 5'd9, 4'd1,  2'd2, 1'b1, 0};
    vecs[2]  = '{8'h00, 4'b0100, 14,  5'd6, 5'd9, 4'd15, 2'd2, 1'b1, 0};
    vecs[3]  = '{8'h00, 4'b0100, 1,   5'd5, 5'd9, 4'd0,  2'd2, 1'b1, 1};
    vecs[4]  = '{8'h00, 4'b0101, 6,   5'd5, 5'd9, 4'd6,  2'd2, 1'b1, 0};
    vecs[5]  = '{8'h1A, 4'b0101, 0,   5'd5, 5'd9, 4'd6,  2'd2, 1'b1, 0};
    vecs[6]  = '{8'h00, 4'b0101, 9,   5'd5, 5'd9, 4'd15, 2'd2, 1'b1, 0};
    vecs[7]  = '{8'h00, 4'b0101, 1,   5'd4, 5'd9, 4'd0,  2'd2, 1'b1, 1};
    vecs[8]  = '{8'h00, 4'b0101, 1,   5'd4, 5'd9, 4'd1,  2'd0, 1'b1, 0};
    vecs[9]  = '{8'h00, 4'b0101, 15,  5'd4, 5'd8, 4'd0,  2'd0, 1'b1, 1};
    vecs[10] = '{8'h00, 4'b0000, 5,   5'd4, 5'd8, 4'd0,  2'd0, 1'b0, 0};
    vecs[11] = '{8'h07, 4'b0000, 40,  5'd4, 5'd8, 4'd0,  2'd0, 1'b0, 0};
    vecs[12] = '{8'h00, 4'b1000, 1,   5'd4, 5'd8, 4'd1,  2'd3, 1'b1, 0};
    vecs[13] = '{8'h00, 4'b1000, 15,  5'd5, 5'd8, 4'd0,  2'd3, 1'b1, 1};
    vecs[14] = '{8'h00, 4'b0000, 5,   5'd5, 5'd8, 4'd0,  2'd3, 1'b0, 0};
    vecs[15] = '{8'h1A, 4'b0001, 128, 5'd5, 5'd0, 4'd0,  2'd0, 1'b1, 8};
    vecs[16] = '{8'h00, 4'b0001, 16,  5'd5, 5'd0, 4'd0,  2'd0, 1'b1, 1};
    vecs[17] = '{8'h00, 4'b0000, 1,   5'd5, 5'd0, 4'd0,  2'd0, 1'b0, 0};
    vecs[18] = '{8'h05, 4'b1111, 3,   5'd5, 5'd0, 4'd0,  2'd0, 1'b0, 0};

    rst_n               = 1'b0;
    bus.frame_clk       = 1'b0;
    bus.Starting_screen = 1'b0;
    bus.keycode         = 8'h00;
    set_flags(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 5'd6, 5'd9, 4'd0, 2'd2, 1'b0, 0, int'(bus.tile_tick));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 19; v++) begin
      set_flags(vecs[v].flags);
      if (vecs[v].key != 8'h00) press(vecs[v].key);
      frame_ticks(vecs[v].ticks, tt);
      chk_all($sformatf("vec%0d", v), vecs[v].x, vecs[v].y, vecs[v].off,
              vecs[v].dir, vecs[v].mv, vecs[v].tt, tt);
    end

    // Key load coinciding with a CENTER decision: decided on the old (empty)
    // pending slot, the new key is taken on the following tick.
    set_flags(4'b1111);
    bus.keycode   = KEY_D;
    bus.frame_clk = 1'b1;
    @(posedge clk); #1;
    bus.keycode   = 8'h00;
    bus.frame_clk = 1'b0;
    chk_all("same_cycle_key", 5'd5, 5'd0, 4'd0, 2'd0, 1'b0, 0, int'(bus.tile_tick));
    @(posedge clk); #1;
    frame_ticks(1, tt);
    chk_all("queued_key_taken", 5'd5, 5'd0, 4'd1, 2'd3, 1'b1, 0, tt);
    frame_ticks(6, tt);
    chk_all("mid_move_off7", 5'd5, 5'd0, 4'd7, 2'd3, 1'b1, 0, tt);

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 5'd6, 5'd9, 4'd0, 2'd2, 1'b0, 0, int'(bus.tile_tick));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frame_clk pulses each advance the offset.
    frame_ticks(1, tt);
    press(KEY_A);
    bus.frame_clk = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_off%0d", k), 32'(bus.offset), 32'(k));
    end
    bus.frame_clk = 1'b0;

    // Start screen mid-move forces spawn on the next edge and drops the queue.
    bus.Starting_screen = 1'b1;
    @(posedge clk); #1;
    chk_all("start_screen", 5'd6, 5'd9, 4'd0, 2'd2, 1'b0, 0, int'(bus.tile_tick));
    bus.Starting_screen = 1'b0;
    frame_ticks(3, tt);
    chk_all("after_start", 5'd6, 5'd9, 4'd0, 2'd2, 1'b0, 0, tt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
